ads127l01_fsync_rx: RTL

- Receive-side deserializer for the ADS127L01 in frame-sync master mode; sits directly downstream of the ADC (or its bench model).
- Oversamples the ADC's sck, dout and fsync in the system clk domain and reassembles 24-bit MSB-first samples.
- Presents each sample on a valid/ready output to the decimation/DAQ pipeline, with frame-error and overrun reporting.

---
 rtl/ads127l01_fsync_rx.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ads127l01_fsync_rx.sv
// ADS127L01 frame-sync master-mode receiver.
// Oversamples sck/dout/fsync in the clk domain and rebuilds DW-bit MSB-first
// samples. Each sample is presented on a valid/ready output register, with a
// frame_err pulse for aborted frames and a sticky overrun flag for dropped words.
module ads127l01_fsync_rx #(
  parameter int DW          = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          sck,
  input  logic          dout,
  input  logic          fsync,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          frame_err,
  output logic          overrun
);

  localparam int CW = $clog2(DW + 1);
  // fsync must still be high while fewer than this many bits are shifted
  localparam int MIN_FSYNC_BITS = 15;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] dout_sync_q, dout_sync_d;
  logic [SYNC_STAGES-1:0] fsync_sync_q, fsync_sync_d;
  logic                   sck_hist_q, sck_hist_d;
  logic                   fsync_last_q, fsync_last_d;
  state_t                 state_q, state_d;
  logic [DW-1:0]          shift_q, shift_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic                   load_req_q, load_req_d;
  logic [DW-1:0]          out_data_q, out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_q, overrun_d;

  logic sck_s, dout_s, fsync_s;
  logic sck_rise, frame_start;

  assign sck_s       = sck_sync_q[SYNC_STAGES-1];
  assign dout_s      = dout_sync_q[SYNC_STAGES-1];
  assign fsync_s     = fsync_sync_q[SYNC_STAGES-1];
  assign sck_rise    = sck_s & ~sck_hist_q;
  // A frame begins on the first sck rise that sees fsync go high
  assign frame_start = sck_rise & fsync_s & ~fsync_last_q;

  // Next-state logic for synchronizers, capture FSM and output register
  always_comb begin
    sck_sync_d   = {sck_sync_q[SYNC_STAGES-2:0], sck};
    dout_sync_d  = {dout_sync_q[SYNC_STAGES-2:0], dout};
    fsync_sync_d = {fsync_sync_q[SYNC_STAGES-2:0], fsync};
    sck_hist_d   = sck_s;
    fsync_last_d = sck_rise ? fsync_s : fsync_last_q;
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    load_req_d   = 1'b0;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    frame_err_d  = 1'b0;
    overrun_d    = overrun_q;

    if (!en) begin
      state_d   = IDLE;
      shift_d   = '0;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_start) begin
            shift_d   = {{(DW-1){1'b0}}, dout_s};
            bit_cnt_d = CW'(1);
            state_d   = SHIFT;
          end
        end
        SHIFT: begin
          if (frame_start) begin
            // Unexpected new frame: abort and restart on its first bit
            frame_err_d = 1'b1;
            shift_d     = {{(DW-1){1'b0}}, dout_s};
            bit_cnt_d   = CW'(1);
          end else if (sck_rise && !fsync_s && (int'(bit_cnt_q) < MIN_FSYNC_BITS)) begin
            frame_err_d = 1'b1;
            shift_d     = '0;
            bit_cnt_d   = '0;
            state_d     = IDLE;
          end else if (sck_rise) begin
            shift_d = {shift_q[DW-2:0], dout_s};
            if (bit_cnt_q == CW'(DW - 1)) begin
              bit_cnt_d  = '0;
              load_req_d = 1'b1;
              state_d    = DONE;
            end else begin
              bit_cnt_d = bit_cnt_q + CW'(1);
            end
          end
        end
        DONE: begin
          // Skip padding bits until the fsync-high window has ended
          if (!fsync_last_q) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end

    if (load_req_q) begin
      if (!out_valid_q || out_ready) begin
        out_data_d  = shift_q;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (!en) overrun_d = 1'b0;
  end

  // All state registers, asynchronously reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q   <= '0;
      dout_sync_q  <= '0;
      fsync_sync_q <= '0;
      sck_hist_q   <= 1'b0;
      fsync_last_q <= 1'b0;
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      load_req_q   <= 1'b0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sck_sync_q   <= sck_sync_d;
      dout_sync_q  <= dout_sync_d;
      fsync_sync_q <= fsync_sync_d;
      sck_hist_q   <= sck_hist_d;
      fsync_last_q <= fsync_last_d;
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      load_req_q   <= load_req_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
